wb_j1_bus_arbiter: RTL and testbench

//  Round-robin Wishbone arbiter that lets N_CPU j1 cores share one memory/peripheral slave.

---
 rtl/wb_j1_bus_arbiter.sv | 148 ++++++++++++++
 tb/tb_wb_j1_bus_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_j1_bus_arbiter.sv
// Round-robin Wishbone arbiter: N_CPU j1 cores share one slave, with a bus timeout and owner tagging.
// Latency: request seen in IDLE -> slave cycle next clock; ack/read data pass back combinationally.
// Backpressure: a core holds cyc until its ack; non-granted cores wait until the bus returns to IDLE.
module wb_j1_bus_arbiter #(
    parameter int N_CPU   = 4,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_CPU-1:0]    m_cyc_i,
    input  logic [N_CPU-1:0]    m_we_i,
    input  logic [N_CPU*DW-1:0] m_adr_i,
    input  logic [N_CPU*DW-1:0] m_dat_i,
    output logic [N_CPU-1:0]    m_ack_o,
    output logic [DW-1:0]       m_dat_o,
    output logic                s_cyc_o,
    output logic                s_we_o,
    output logic [DW-1:0]       s_adr_o,
    output logic [DW-1:0]       s_dat_o,
    input  logic [DW-1:0]       s_dat_i,
    input  logic                s_ack_i,
    output logic [2:0]          s_cpu_num_o,
    output logic                timeout_o,
    output logic [7:0]          timeout_cnt_o
);

    localparam logic [2:0]  LAST_RST  = 3'(N_CPU - 1);
    localparam logic [15:0] TCNT_LAST = 16'(TIMEOUT - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state_q, state_d;
    logic [2:0]  grant_q, grant_d;
    logic [2:0]  last_q, last_d;
    logic [15:0] tcnt_q, tcnt_d;
    logic [7:0]  tocnt_q, tocnt_d;

    logic             g_cyc, g_we;
    logic [DW-1:0]    g_adr, g_dat;
    logic [N_CPU-1:0] g_onehot;
    logic             pick_vld;
    logic [2:0]       pick_idx;

    always_comb begin
        g_cyc    = 1'b0;
        g_we     = 1'b0;
        g_adr    = '0;
        g_dat    = '0;
        g_onehot = '0;
        for (int k = 0; k < N_CPU; k++) begin
            if (grant_q == 3'(k)) begin
                g_cyc       = m_cyc_i[k];
                g_we        = m_we_i[k];
                g_adr       = m_adr_i[k*DW +: DW];
                g_dat       = m_dat_i[k*DW +: DW];
                g_onehot[k] = 1'b1;
            end
        end
    end

    // Search starts just after the last owner so every waiting core is reached within N_CPU-1 grants.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int off = 1; off <= N_CPU; off++) begin
            for (int k = 0; k < N_CPU; k++) begin
                if (!pick_vld && m_cyc_i[k] && (k == (int'(last_q) + off) % N_CPU)) begin
                    pick_vld = 1'b1;
                    pick_idx = 3'(k);
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        tcnt_d      = tcnt_q;
        tocnt_d     = tocnt_q;
        m_ack_o     = '0;
        m_dat_o     = '0;
        s_cyc_o     = 1'b0;
        s_we_o      = 1'b0;
        s_adr_o     = '0;
        s_dat_o     = '0;
        s_cpu_num_o = '0;
        timeout_o   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    grant_d = pick_idx;
                    tcnt_d  = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                s_cyc_o     = g_cyc;
                s_we_o      = g_we;
                s_adr_o     = g_adr;
                s_dat_o     = g_dat;
                s_cpu_num_o = grant_q;
                // An abort wins over a same-cycle slave ack: the core has already moved on.
                if (!g_cyc) begin
                    last_d  = grant_q;
                    state_d = IDLE;
                end else if (s_ack_i) begin
                    m_ack_o = g_onehot;
                    m_dat_o = s_dat_i;
                    last_d  = grant_q;
                    state_d = IDLE;
                end else if (tcnt_q == TCNT_LAST) begin
                    m_ack_o   = g_onehot;
                    timeout_o = 1'b1;
                    s_cyc_o   = 1'b0;
                    if (tocnt_q != 8'hFF) begin
                        tocnt_d = tocnt_q + 8'd1;
                    end
                    last_d  = grant_q;
                    state_d = IDLE;
                end else begin
                    tcnt_d = tcnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign timeout_cnt_o = tocnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= LAST_RST;
            tcnt_q  <= '0;
            tocnt_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            tcnt_q  <= tcnt_d;
            tocnt_q <= tocnt_d;
        end
    end

endmodule

// File: tb/tb_wb_j1_bus_arbiter.sv
// Bench for wb_j1_bus_arbiter: directed stimulus pushes expected acks into a queue,
// a negedge monitor pops and compares whenever the arbiter acks a core.
module tb_wb_j1_bus_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int TO = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   m_cyc_i, m_we_i;
    logic [N*DW-1:0] m_adr_i, m_dat_i;
    logic [N-1:0]   m_ack_o;
    logic [DW-1:0]  m_dat_o;
    logic           s_cyc_o, s_we_o;
    logic [DW-1:0]  s_adr_o, s_dat_o;
    logic [DW-1:0]  s_dat_i;
    logic           s_ack_i;
    logic [2:0]     s_cpu_num_o;
    logic           timeout_o;
    logic [7:0]     timeout_cnt_o;

    always #5 clk = ~clk;

    wb_j1_bus_arbiter #(.N_CPU(N), .DW(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .m_cyc_i(m_cyc_i), .m_we_i(m_we_i), .m_adr_i(m_adr_i), .m_dat_i(m_dat_i),
        .m_ack_o(m_ack_o), .m_dat_o(m_dat_o),
        .s_cyc_o(s_cyc_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_cpu_num_o(s_cpu_num_o),
        .timeout_o(timeout_o), .timeout_cnt_o(timeout_cnt_o)
    );

    typedef struct {
        logic [N-1:0]  ack;
        logic [DW-1:0] dat;
        logic          tmo;
        logic          scyc;
        logic [2:0]    cpu;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int errors = 0;
    int checks = 0;
    int cyc_n  = 0;

    int scnt = 0;
    int slave_wait = 0;
    bit slave_mute = 1'b0;
    bit slave_manual = 1'b0;

    always @(posedge clk) cyc_n++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic push(input logic [N-1:0] ack, input logic [DW-1:0] dat, input logic tmo,
                        input logic scyc, input logic [2:0] cpu);
        exp_t e;
        e.ack = ack; e.dat = dat; e.tmo = tmo; e.scyc = scyc; e.cpu = cpu;
        exp_q.push_back(e);
    endtask

    // Monitor: every ack event is matched against the next expected response.
    always @(negedge clk) begin
        if (rst) begin
            if (m_ack_o != '0) begin
                chk("ack_onehot", 64'($onehot(m_ack_o)), 64'd1);
                if (exp_q.size() == 0) begin
                    chk("unexpected_ack", 64'(m_ack_o), 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("ack_vec", 64'(m_ack_o), 64'(mon_e.ack));
                    chk("ack_rdata", 64'(m_dat_o), 64'(mon_e.dat));
                    chk("ack_timeout", 64'(timeout_o), 64'(mon_e.tmo));
                    chk("ack_s_cyc", 64'(s_cyc_o), 64'(mon_e.scyc));
                    if (mon_e.scyc) chk("ack_cpu_num", 64'(s_cpu_num_o), 64'(mon_e.cpu));
                end
            end else begin
                chk("noack_dat_tmo", 64'({m_dat_o, timeout_o}), 64'd0);
            end
        end
    end

    // Slave model: acks after slave_wait cycles of s_cyc_o unless muted or driven by hand.
    always begin
        @(posedge clk);
        #2;
        if (!slave_manual) begin
            if (s_cyc_o) begin
                s_ack_i = !slave_mute && (scnt == slave_wait);
                scnt++;
            end else begin
                s_ack_i = 1'b0;
                scnt = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input string name, output int at);
        at = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (m_ack_o != '0) begin
                at = cyc_n;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL %s: no ack within 60 cycles", name);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        m_cyc_i = '0; m_we_i = '0; m_adr_i = '0; m_dat_i = '0;
        s_ack_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0, t1, prev;
        s_dat_i = 32'h1111_2222;
        rst = 1'b0;
        m_cyc_i = '0; m_we_i = '0; m_adr_i = '0; m_dat_i = '0;
        s_ack_i = 1'b0;
        @(negedge clk);
        chk("rst_s_cyc", 64'(s_cyc_o), 64'd0);
        chk("rst_m_ack", 64'(m_ack_o), 64'd0);
        chk("rst_tcnt", 64'(timeout_cnt_o), 64'd0);
        do_reset();

        // 1: single write by core 2, zero-wait slave
        slave_wait = 0; slave_mute = 1'b0;
        push(4'b0100, 32'h1111_2222, 1'b0, 1'b1, 3'd2);
        step();
        m_cyc_i = 4'b0100; m_we_i = 4'b0100;
        m_adr_i[2*DW +: DW] = 32'h100; m_dat_i[2*DW +: DW] = 32'hA5;
        @(negedge clk);
        chk("t1_idle_s_cyc", 64'(s_cyc_o), 64'd0);
        @(negedge clk);
        chk("t1_s_fields", {s_cyc_o, s_we_o, s_cpu_num_o, s_adr_o, s_dat_o[26:0]},
            {1'b1, 1'b1, 3'd2, 32'h100, 27'hA5});
        chk("t1_ack_same_cycle", 64'(m_ack_o), 64'(4'b0100));
        step();
        m_cyc_i = '0; m_we_i = '0;
        repeat (3) @(negedge clk);
        chk("t1_queue_empty", 64'(exp_q.size()), 64'd0);

        // 2: all cores continuously, zero-wait slave -> 0,1,2,3,0 every 2 cycles
        do_reset();
        s_dat_i = 32'h0BAD_F00D;
        push(4'b0001, 32'h0BAD_F00D, 1'b0, 1'b1, 3'd0);
        push(4'b0010, 32'h0BAD_F00D, 1'b0, 1'b1, 3'd1);
        push(4'b0100, 32'h0BAD_F00D, 1'b0, 1'b1, 3'd2);
        push(4'b1000, 32'h0BAD_F00D, 1'b0, 1'b1, 3'd3);
        push(4'b0001, 32'h0BAD_F00D, 1'b0, 1'b1, 3'd0);
        step();
        m_cyc_i = 4'hF;
        wait_ack("t2_ack0", prev);
        for (int i = 1; i < 5; i++) begin
            wait_ack("t2_ack", t1);
            chk("t2_spacing", 64'(t1 - prev), 64'd2);
            prev = t1;
        end
        step();
        m_cyc_i = '0;
        repeat (3) @(negedge clk);
        chk("t2_queue_empty", 64'(exp_q.size()), 64'd0);

        // 3: read by core 1, slave answers after 3 wait cycles
        do_reset();
        s_dat_i = 32'hDEAD_BEEF;
        slave_wait = 3;
        push(4'b0010, 32'hDEAD_BEEF, 1'b0, 1'b1, 3'd1);
        step();
        m_cyc_i = 4'b0010; m_adr_i[1*DW +: DW] = 32'h20;
        t0 = cyc_n;
        wait_ack("t3_ack", t1);
        chk("t3_latency", 64'(t1 - t0), 64'd4);
        step();
        m_cyc_i = '0;
        repeat (3) @(negedge clk);
        chk("t3_queue_empty", 64'(exp_q.size()), 64'd0);

        // 4: silent slave -> forced acks, counter saturates at 255
        do_reset();
        s_dat_i = 32'h5555_AAAA;
        slave_mute = 1'b1;
        step();
        m_cyc_i = 4'b0001;
        t0 = cyc_n;
        for (int i = 0; i < 300; i++) begin
            push(4'b0001, 32'h0, 1'b1, 1'b0, 3'd0);
            wait_ack("t4_ack", t1);
            if (i == 0) chk("t4_busy_cycles", 64'(t1 - t0), 64'd8);
            step();
            if (i == 299) m_cyc_i = '0;
            @(negedge clk);
            if (i == 0) chk("t4_cnt_one", 64'(timeout_cnt_o), 64'd1);
            if (i == 254) chk("t4_cnt_255", 64'(timeout_cnt_o), 64'd255);
        end
        chk("t4_cnt_sat", 64'(timeout_cnt_o), 64'd255);

        // 6: async reset mid-BUSY, then core 1 wins over core 2
        step();
        m_cyc_i = 4'b0100;
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_outs_zero", {s_cyc_o, m_ack_o, s_cpu_num_o, timeout_o, s_adr_o, m_dat_o, timeout_cnt_o},
            '0);
        m_cyc_i = 4'b0110;
        slave_mute = 1'b0; slave_wait = 0;
        s_dat_i = 32'h1234_5678;
        push(4'b0010, 32'h1234_5678, 1'b0, 1'b1, 3'd1);
        push(4'b0100, 32'h1234_5678, 1'b0, 1'b1, 3'd2);
        @(negedge clk);
        #2;
        rst = 1'b1;
        wait_ack("t6_ack1", t1);
        wait_ack("t6_ack2", t1);
        step();
        m_cyc_i = '0;
        repeat (3) @(negedge clk);
        chk("t6_queue_empty", 64'(exp_q.size()), 64'd0);

        // 5: core 3 aborts in its 2nd BUSY cycle while the slave acks
        do_reset();
        slave_manual = 1'b1;
        s_ack_i = 1'b0;
        s_dat_i = 32'hCAFE_0001;
        step();
        m_cyc_i = 4'b1000;
        step();
        @(negedge clk);
        chk("t5_busy1", {s_cyc_o, s_cpu_num_o}, {1'b1, 3'd3});
        step();
        m_cyc_i = 4'b0101;
        s_ack_i = 1'b1;
        @(negedge clk);
        chk("t5_abort", {m_ack_o, s_cyc_o}, '0);
        push(4'b0001, 32'hCAFE_0001, 1'b0, 1'b1, 3'd0);
        push(4'b0100, 32'hCAFE_0001, 1'b0, 1'b1, 3'd2);
        step();
        s_ack_i = 1'b0;
        slave_manual = 1'b0;
        @(negedge clk);
        chk("t5_idle", 64'(s_cyc_o), 64'd0);
        wait_ack("t5_ack0", t1);
        wait_ack("t5_ack2", t1);
        step();
        m_cyc_i = '0;
        repeat (3) @(negedge clk);
        chk("t5_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
